axi_mem_port_arbiter: RTL and testbench
=======================================

Name: axi_mem_port_arbiter

Overview:
- Shares one AXI4 master port between two requesters: the instruction-cache refill engine and the uncached data load/store path.
- Instruction requests are INCR bursts of BURST_LEN 32-bit beats. Data requests are single-beat reads or writes.
- One transaction is outstanding at a time. Requesters are granted round-robin.
- Sits between the cache/pipeline memory logic and the single DDR AXI slave, so the two separate AXI ports can be merged.

Parameters:
BURST_LEN, 16, beats per instruction burst (1..256); arlen = BURST_LEN-1
ERR_ON_RLAST, 1, if 1 a missing, early or late rlast is flagged as an error

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
i_req  in  1  level; instruction burst request, held until i_done
i_addr  in  32  burst base address; bits [5:0] ignored, forced to 0 on araddr
i_beat_valid  out  1  one-cycle pulse per received instruction beat
i_beat_data  out  32  beat data, valid with i_beat_valid
i_beat_idx  out  8  beat number 0..BURST_LEN-1, valid with i_beat_valid
i_done  out  1  one-cycle pulse when the burst completes
i_err  out  1  valid with i_done; 1 = bad rresp or rlast mismatch
d_req  in  1  level; data request, held until d_done
d_we  in  1  1 = write, 0 = read; sampled at grant
d_addr  in  32  data byte address, sampled at grant
d_wdata  in  32  write data, sampled at grant
d_wstrb  in  4  write byte mask, sampled at grant
d_done  out  1  one-cycle pulse when the data access completes
d_rdata  out  32  read data; valid with d_done, held until the next read
d_err  out  1  valid with d_done; 1 = non-OKAY resp or rlast mismatch
m_awvalid/m_awready/m_awaddr[31:0]/m_awlen[7:0]/m_awsize[2:0]/m_awburst[1:0]  AXI write-address channel, out/in/out...
m_wvalid/m_wready/m_wdata[31:0]/m_wstrb[3:0]/m_wlast  AXI write-data channel
m_bvalid/m_bready/m_bresp[1:0]  AXI write-response channel
m_arvalid/m_arready/m_araddr[31:0]/m_arlen[7:0]/m_arsize[2:0]/m_arburst[1:0]  AXI read-address channel
m_rvalid/m_rready/m_rdata[31:0]/m_rresp[1:0]/m_rlast  AXI read-data channel

Behaviour:
- Reset values:
  - All *valid outputs, i_beat_valid, i_done, d_done, i_err, d_err = 0.
  - m_bready = m_rready = 1 and stay constant.
  - m_awsize = m_arsize = 3'b010; m_wlast = 1; m_awlen = 0; m_awburst = 0.
  - State IDLE; rr_last = DATA, so instruction wins the first tie; d_rdata = 0.
- States: IDLE, I_AR, I_R, D_AR, D_R, D_AW_W, D_B.
- IDLE grant:
  - If exactly one req is high, grant it. If both are high, grant the requester not in rr_last, then update rr_last.
  - Address and data are captured in the grant cycle. The AXI valid rises on the next cycle (1-cycle grant latency).
- Instruction grant: go to I_AR with m_araddr = {i_addr[31:6],6'b0}, m_arlen = BURST_LEN-1, m_arburst = INCR (1).
  - I_AR: drop arvalid on arready, then go to I_R.
  - I_R: for each rvalid beat, pulse i_beat_valid with i_beat_idx = beat counter, then increment the counter.
  - Any rresp != 0 sets the sticky error bit.
  - rlast on beat != BURST_LEN-1, or no rlast on beat BURST_LEN-1, sets the error bit when ERR_ON_RLAST = 1.
  - The burst ends on rlast, or on beat BURST_LEN-1 if rlast is missing. The end beat pulses i_done and drives i_err in the same cycle; the next state is IDLE.
- Data read: D_AR, then D_R (arlen = 0, arburst = 0).
  - On the rvalid beat: d_rdata <= rdata; d_done pulses the following cycle.
  - d_err = (rresp != 0) || (ERR_ON_RLAST && !rlast).
- Data write: D_AW_W asserts awvalid and wvalid together. Each valid drops independently on its own ready.
  - When both handshakes are done (same cycle or different cycles), go to D_B.
  - On bvalid: d_done pulses with d_err = (bresp != 0).
- Back-to-back: the cycle after a done pulse is IDLE. A new grant may occur in that IDLE cycle, so the minimum gap between transactions is 1 cycle.
- A requester must keep req high until its done pulse and drop it within 1 cycle after. A req high in the done cycle itself is not regranted.
- Unsolicited rvalid/bvalid (in IDLE or an address state) is ignored. No output changes.
- Single outstanding transaction: a second read is never issued before the first completes, so r-channel interleaving cannot occur.
- Reset mid-operation: return to IDLE and drop all valids in the next cycle. Pending beats are discarded with no done pulse. The AXI slave is reset by the same rst.

Test Plan:
- i_req only, i_addr = 0x0000_1234: araddr = 0x0000_1200, arlen = 15, arburst = 1. The slave returns data 0..15 with rlast on beat 15 → 16 i_beat_valid pulses with idx 0..15, then i_done = 1, i_err = 0.
- i_req and d_req both rise in the same cycle after reset → instruction burst first. The data read at 0x8000_0010 follows with a 1-cycle IDLE gap. Next tie → data first.
- Data write, addr 0x10, wdata 0xDEADBEEF, wstrb 4'b0011. awready is delayed 3 cycles; wready is immediate → bresp = 0 gives d_done = 1, d_err = 0. Single AW and W handshake each.
- Data read with rresp = 2'b10 → d_done with d_err = 1. Instruction burst with rlast asserted on beat 7 → i_done on beat 7 with i_err = 1.
- rst asserted during beat 5 of a burst → valids low next cycle, no i_done. A new d_req after reset is granted normally.
- Stuck slave on arready for 100 cycles → arvalid and araddr stay stable throughout, with no grant change.

Source files
------------

// File: rtl/axi_mem_port_arbiter.sv
// Merges the I-cache refill burst path and the uncached data path onto one AXI4 master.
// One transaction in flight at a time; round-robin on simultaneous requests.
module axi_mem_port_arbiter #(
   parameter int unsigned BURST_LEN    = 16,
   parameter bit          ERR_ON_RLAST = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   // instruction refill requester
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_beat_valid,
   output logic [31:0] i_beat_data,
   output logic [7:0]  i_beat_idx,
   output logic        i_done,
   output logic        i_err,
   // uncached data requester
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wstrb,
   output logic        d_done,
   output logic [31:0] d_rdata,
   output logic        d_err,
   // AXI4 master
   output logic        m_awvalid,
   input  logic        m_awready,
   output logic [31:0] m_awaddr,
   output logic [7:0]  m_awlen,
   output logic [2:0]  m_awsize,
   output logic [1:0]  m_awburst,
   output logic        m_wvalid,
   input  logic        m_wready,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_wstrb,
   output logic        m_wlast,
   input  logic        m_bvalid,
   output logic        m_bready,
   input  logic [1:0]  m_bresp,
   output logic        m_arvalid,
   input  logic        m_arready,
   output logic [31:0] m_araddr,
   output logic [7:0]  m_arlen,
   output logic [2:0]  m_arsize,
   output logic [1:0]  m_arburst,
   input  logic        m_rvalid,
   output logic        m_rready,
   input  logic [31:0] m_rdata,
   input  logic [1:0]  m_rresp,
   input  logic        m_rlast
);

   localparam logic [7:0] LastBeat = 8'(BURST_LEN - 1);

   typedef enum logic [2:0] {
      StIdle, StIAr, StIR, StDAr, StDR, StDAwW, StDB
   } state_e;

   state_e      r_state, w_state_next;
   logic        r_arvalid, r_awvalid, r_wvalid;
   logic [31:0] r_araddr, r_awaddr, r_wdata;
   logic [7:0]  r_arlen;
   logic [1:0]  r_arburst;
   logic [3:0]  r_wstrb;
   logic [7:0]  r_beat_cnt;
   logic        r_i_err;
   logic        r_rr_last_i;  // 1 when the last tie went to the instruction side
   logic        r_rd_got;
   logic        r_d_err;
   logic [31:0] r_d_rdata;

   logic w_grant_i, w_grant_d;
   logic w_ibeat, w_beat_last, w_iend, w_beat_err;
   logic w_aw_done, w_w_done;
   logic w_unused;

   assign w_unused = ^i_addr[5:0];

   assign w_grant_i = i_req && (!d_req || !r_rr_last_i);
   assign w_grant_d = d_req && (!i_req || r_rr_last_i);

   assign w_ibeat     = (r_state == StIR) && m_rvalid;
   assign w_beat_last = (r_beat_cnt == LastBeat);
   assign w_iend      = w_ibeat && (m_rlast || w_beat_last);
   assign w_beat_err  = (m_rresp != 2'b00) || (ERR_ON_RLAST && (m_rlast != w_beat_last));

   assign w_aw_done = !r_awvalid || m_awready;
   assign w_w_done  = !r_wvalid || m_wready;

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= StIdle;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle: begin
            if (w_grant_i)      w_state_next = StIAr;
            else if (w_grant_d) w_state_next = d_we ? StDAwW : StDAr;
         end
         StIAr:  if (m_arready) w_state_next = StIR;
         StIR:   if (w_iend) w_state_next = StIdle;
         StDAr:  if (m_arready) w_state_next = StDR;
         StDR:   if (r_rd_got) w_state_next = StIdle;
         StDAwW: if (w_aw_done && w_w_done) w_state_next = StDB;
         StDB:   if (m_bvalid) w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_arvalid   <= 1'b0;
         r_awvalid   <= 1'b0;
         r_wvalid    <= 1'b0;
         r_araddr    <= '0;
         r_awaddr    <= '0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
         r_arlen     <= '0;
         r_arburst   <= '0;
         r_beat_cnt  <= '0;
         r_i_err     <= 1'b0;
         r_rr_last_i <= 1'b0;
         r_rd_got    <= 1'b0;
         r_d_err     <= 1'b0;
         r_d_rdata   <= '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_grant_i) begin
                  r_araddr   <= {i_addr[31:6], 6'b0};
                  r_arlen    <= LastBeat;
                  r_arburst  <= 2'b01;
                  r_arvalid  <= 1'b1;
                  r_beat_cnt <= '0;
                  r_i_err    <= 1'b0;
                  // round-robin pointer only moves on a tie
                  if (d_req) r_rr_last_i <= 1'b1;
               end else if (w_grant_d) begin
                  if (i_req) r_rr_last_i <= 1'b0;
                  r_rd_got <= 1'b0;
                  if (d_we) begin
                     r_awaddr  <= d_addr;
                     r_wdata   <= d_wdata;
                     r_wstrb   <= d_wstrb;
                     r_awvalid <= 1'b1;
                     r_wvalid  <= 1'b1;
                  end else begin
                     r_araddr  <= d_addr;
                     r_arlen   <= 8'd0;
                     r_arburst <= 2'b00;
                     r_arvalid <= 1'b1;
                  end
               end
            end
            StIAr, StDAr: if (m_arready) r_arvalid <= 1'b0;
            StIR: begin
               if (w_ibeat) begin
                  r_beat_cnt <= r_beat_cnt + 8'd1;
                  if (w_beat_err) r_i_err <= 1'b1;
               end
            end
            StDR: begin
               if (m_rvalid && !r_rd_got) begin
                  r_rd_got  <= 1'b1;
                  r_d_rdata <= m_rdata;
                  r_d_err   <= (m_rresp != 2'b00) || (ERR_ON_RLAST && !m_rlast);
               end
            end
            StDAwW: begin
               if (m_awready) r_awvalid <= 1'b0;
               if (m_wready)  r_wvalid  <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign i_beat_valid = w_ibeat;
   assign i_beat_data  = m_rdata;
   assign i_beat_idx   = r_beat_cnt;
   assign i_done       = w_iend;
   assign i_err        = w_iend && (r_i_err || w_beat_err);

   assign d_done  = ((r_state == StDR) && r_rd_got) || ((r_state == StDB) && m_bvalid);
   assign d_err   = ((r_state == StDR) && r_rd_got && r_d_err) ||
                    ((r_state == StDB) && m_bvalid && (m_bresp != 2'b00));
   assign d_rdata = r_d_rdata;

   assign m_arvalid = r_arvalid;
   assign m_araddr  = r_araddr;
   assign m_arlen   = r_arlen;
   assign m_arsize  = 3'b010;
   assign m_arburst = r_arburst;
   assign m_rready  = 1'b1;

   assign m_awvalid = r_awvalid;
   assign m_awaddr  = r_awaddr;
   assign m_awlen   = 8'd0;
   assign m_awsize  = 3'b010;
   assign m_awburst = 2'b00;
   assign m_wvalid  = r_wvalid;
   assign m_wdata   = r_wdata;
   assign m_wstrb   = r_wstrb;
   assign m_wlast   = 1'b1;
   assign m_bready  = 1'b1;

endmodule

// File: tb/tb_axi_mem_port_arbiter.sv
// Scoreboard bench for axi_mem_port_arbiter: directed stimulus pushes expected events,
// a negedge monitor pops and compares them, and a behavioural AXI slave answers the port.
module tb_axi_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, d_req, d_we;
   logic [31:0] i_addr, d_addr, d_wdata;
   logic [3:0]  d_wstrb;
   logic        i_beat_valid, i_done, i_err, d_done, d_err;
   logic [31:0] i_beat_data, d_rdata;
   logic [7:0]  i_beat_idx;
   logic        m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
   logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
   logic [7:0]  m_awlen, m_arlen;
   logic [2:0]  m_awsize, m_arsize;
   logic [1:0]  m_awburst, m_bresp, m_arburst, m_rresp;
   logic [3:0]  m_wstrb;
   logic        m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;

   always #5 clk = ~clk;

   axi_mem_port_arbiter dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_beat_valid(i_beat_valid), .i_beat_data(i_beat_data),
      .i_beat_idx(i_beat_idx), .i_done(i_done), .i_err(i_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
      .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
      .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
      .m_awsize(m_awsize), .m_awburst(m_awburst),
      .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_wlast(m_wlast), .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
      .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
      .m_arsize(m_arsize), .m_arburst(m_arburst),
      .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
      .m_rlast(m_rlast)
   );

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
   } exp_t;

   exp_t q_ar[$], q_aw[$], q_w[$], q_beat[$], q_idone[$], q_ddone[$];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int idone_cyc = 0;
   int ar_rise_cyc = 0;
   logic prev_arvalid = 1'b0;
   logic [31:0] last_rd = 32'h0;

   // slave configuration
   int          ar_delay = 0, aw_delay = 0, w_delay = 0, rlast_beat = -1;
   logic [31:0] rbase = 32'h0;
   logic [1:0]  rresp_cfg = 2'b00, bresp_cfg = 2'b00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
      end
   endtask

   task automatic fail_evt(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: event seen, none required", name);
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin : monitor
      exp_t e;
      cyc++;
      if (!rst) begin
         if (m_arvalid && !prev_arvalid) ar_rise_cyc = cyc;
         if (m_arvalid && m_arready) begin
            if (q_ar.size() == 0) fail_evt("unexpected AR");
            else begin
               e = q_ar.pop_front();
               chk("araddr", m_araddr, e.a);
               chk("arlen", 32'(m_arlen), e.b);
               chk("arburst", 32'(m_arburst), e.c);
            end
         end
         if (m_awvalid && m_awready) begin
            if (q_aw.size() == 0) fail_evt("unexpected AW");
            else begin
               e = q_aw.pop_front();
               chk("awaddr", m_awaddr, e.a);
               chk("awlen", 32'(m_awlen), e.b);
            end
         end
         if (m_wvalid && m_wready) begin
            if (q_w.size() == 0) fail_evt("unexpected W");
            else begin
               e = q_w.pop_front();
               chk("wdata", m_wdata, e.a);
               chk("wstrb", 32'(m_wstrb), e.b);
               chk("wlast", 32'(m_wlast), e.c);
            end
         end
         if (i_beat_valid) begin
            if (q_beat.size() == 0) fail_evt("unexpected i_beat_valid");
            else begin
               e = q_beat.pop_front();
               chk("i_beat_idx", 32'(i_beat_idx), e.a);
               chk("i_beat_data", i_beat_data, e.b);
            end
         end
         if (i_done) begin
            idone_cyc = cyc;
            if (q_idone.size() == 0) fail_evt("unexpected i_done");
            else begin
               e = q_idone.pop_front();
               chk("i_err", 32'(i_err), e.a);
            end
         end
         if (d_done) begin
            if (q_ddone.size() == 0) fail_evt("unexpected d_done");
            else begin
               e = q_ddone.pop_front();
               chk("d_rdata", d_rdata, e.a);
               chk("d_err", 32'(d_err), e.b);
            end
         end
      end
      prev_arvalid = m_arvalid;
   end

   // ---------------- AXI slave model ----------------
   initial begin : slave
      int ar_cnt, aw_cnt, w_cnt, r_beats, r_idx;
      bit r_act, aw_got, w_got;
      bit s_ar, s_aw, s_w, s_r, s_rl, s_b;
      int s_len;
      ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_beats = 0; r_idx = 0;
      r_act = 0; aw_got = 0; w_got = 0; s_len = 0;
      m_arready = 0; m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
      m_rvalid = 0; m_rdata = 0; m_rresp = 0; m_rlast = 0;
      forever begin
         @(negedge clk);
         s_ar = m_arvalid && m_arready;
         s_aw = m_awvalid && m_awready;
         s_w  = m_wvalid && m_wready;
         s_r  = m_rvalid;
         s_rl = m_rlast;
         s_b  = m_bvalid;
         s_len = int'(m_arlen);
         @(posedge clk);
         #1;
         if (rst) begin
            ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_act = 0; aw_got = 0; w_got = 0;
            m_arready = 0; m_awready = 0; m_wready = 0; m_bvalid = 0; m_rvalid = 0;
         end else begin
            if (s_ar) begin
               r_act = 1; r_beats = s_len + 1; r_idx = 0;
            end
            if (s_r) begin
               r_idx++;
               if (s_rl || r_idx == r_beats) r_act = 0;
            end
            m_rvalid = r_act;
            m_rdata  = rbase + 32'(r_idx);
            m_rresp  = rresp_cfg;
            m_rlast  = (rlast_beat >= 0) ? (r_idx == rlast_beat) : (r_idx == r_beats - 1);
            if (s_ar) begin m_arready = 0; ar_cnt = 0; end
            else if (m_arvalid) begin
               if (ar_cnt >= ar_delay) m_arready = 1; else ar_cnt++;
            end
            if (s_aw) begin m_awready = 0; aw_cnt = 0; aw_got = 1; end
            else if (m_awvalid) begin
               if (aw_cnt >= aw_delay) m_awready = 1; else aw_cnt++;
            end
            if (s_w) begin m_wready = 0; w_cnt = 0; w_got = 1; end
            else if (m_wvalid) begin
               if (w_cnt >= w_delay) m_wready = 1; else w_cnt++;
            end
            if (s_b) m_bvalid = 0;
            else if (aw_got && w_got) begin
               m_bvalid = 1; m_bresp = bresp_cfg; aw_got = 0; w_got = 0;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic push_iburst(input logic [31:0] araddr, input int nbeats, input bit err);
      q_ar.push_back('{a: araddr, b: 32'd15, c: 32'd1});
      for (int k = 0; k < nbeats; k++) q_beat.push_back('{a: 32'(k), b: rbase + 32'(k), c: 0});
      q_idone.push_back('{a: 32'(err), b: 0, c: 0});
   endtask

   task automatic push_dread(input logic [31:0] addr, input logic [31:0] rd, input bit err);
      q_ar.push_back('{a: addr, b: 32'd0, c: 32'd0});
      q_ddone.push_back('{a: rd, b: 32'(err), c: 0});
      last_rd = rd;
   endtask

   task automatic push_dwrite(input logic [31:0] addr, input logic [31:0] wd,
                              input logic [3:0] ws, input bit err);
      q_aw.push_back('{a: addr, b: 32'd0, c: 0});
      q_w.push_back('{a: wd, b: 32'(ws), c: 32'd1});
      q_ddone.push_back('{a: last_rd, b: 32'(err), c: 0});
   endtask

   function automatic bit all_empty();
      return q_ar.size() == 0 && q_aw.size() == 0 && q_w.size() == 0 &&
             q_beat.size() == 0 && q_idone.size() == 0 && q_ddone.size() == 0;
   endfunction

   // Drops each req the cycle after its done and runs until everything is consumed.
   task automatic run(input int budget);
      bit di, dd, fin;
      fin = 0;
      for (int k = 0; k < budget && !fin; k++) begin
         @(negedge clk);
         di = i_done;
         dd = d_done;
         if (!i_req && !d_req && all_empty()) fin = 1;
         else begin
            @(posedge clk);
            #2;
            if (di) i_req = 0;
            if (dd) d_req = 0;
         end
      end
      chk("run completed in budget", 32'(fin), 32'd1);
      if (!fin) begin
         i_req = 0; d_req = 0;
         q_ar.delete(); q_aw.delete(); q_w.delete();
         q_beat.delete(); q_idone.delete(); q_ddone.delete();
      end
   endtask

   // ---------------- directed tests ----------------
   initial begin : stim
      bit seen;
      rst = 1; i_req = 0; d_req = 0; d_we = 0;
      i_addr = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
      repeat (3) @(posedge clk);
      #2 rst = 0;

      @(negedge clk);
      chk("rst arvalid", 32'(m_arvalid), 0);
      chk("rst awvalid", 32'(m_awvalid), 0);
      chk("rst wvalid", 32'(m_wvalid), 0);
      chk("rst i_beat_valid", 32'(i_beat_valid), 0);
      chk("rst i_done", 32'(i_done), 0);
      chk("rst i_err", 32'(i_err), 0);
      chk("rst d_done", 32'(d_done), 0);
      chk("rst d_err", 32'(d_err), 0);
      chk("rst bready", 32'(m_bready), 1);
      chk("rst rready", 32'(m_rready), 1);
      chk("rst arsize", 32'(m_arsize), 2);
      chk("rst awsize", 32'(m_awsize), 2);
      chk("rst wlast", 32'(m_wlast), 1);
      chk("rst awlen", 32'(m_awlen), 0);
      chk("rst awburst", 32'(m_awburst), 0);
      chk("rst d_rdata", d_rdata, 0);

      // instruction burst alone, unaligned address
      rbase = 32'h0;
      push_iburst(32'h0000_1200, 16, 0);
      @(posedge clk); #2;
      i_addr = 32'h0000_1234; i_req = 1;
      run(200);

      // tie after reset state: instruction first, then data read one IDLE cycle later
      rbase = 32'h100;
      push_iburst(32'h0000_4000, 16, 0);
      push_dread(32'h8000_0010, 32'h100, 0);
      @(posedge clk); #2;
      i_addr = 32'h0000_4000; i_req = 1;
      d_we = 0; d_addr = 32'h8000_0010; d_req = 1;
      run(300);
      chk("data AR rise after i_done", 32'(ar_rise_cyc - idone_cyc), 32'd2);

      // next tie: data first
      push_dread(32'h8000_0020, 32'h100, 0);
      push_iburst(32'h0000_2000, 16, 0);
      @(posedge clk); #2;
      i_addr = 32'h0000_2010; i_req = 1;
      d_we = 0; d_addr = 32'h8000_0020; d_req = 1;
      run(300);

      // write with awready delayed 3 cycles, wready immediate
      aw_delay = 3;
      push_dwrite(32'h0000_0010, 32'hDEAD_BEEF, 4'b0011, 0);
      @(posedge clk); #2;
      d_we = 1; d_addr = 32'h0000_0010; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011; d_req = 1;
      run(100);
      aw_delay = 0;

      // data read with SLVERR
      rresp_cfg = 2'b10; rbase = 32'h55AA_0000;
      push_dread(32'h8000_0040, 32'h55AA_0000, 1);
      @(posedge clk); #2;
      d_we = 0; d_addr = 32'h8000_0040; d_req = 1;
      run(100);
      rresp_cfg = 2'b00;

      // early rlast on beat 7
      rlast_beat = 7; rbase = 32'h200;
      push_iburst(32'h0000_3000, 8, 1);
      @(posedge clk); #2;
      i_addr = 32'h0000_3000; i_req = 1;
      run(200);
      rlast_beat = -1;

      // reset during beat 5: beats 0..4 delivered, no i_done
      rbase = 32'h0;
      q_ar.push_back('{a: 32'h0000_5000, b: 32'd15, c: 32'd1});
      for (int k = 0; k < 5; k++) q_beat.push_back('{a: 32'(k), b: 32'(k), c: 0});
      @(posedge clk); #2;
      i_addr = 32'h0000_5000; i_req = 1;
      seen = 0;
      for (int k = 0; k < 200 && !seen; k++) begin
         @(negedge clk);
         if (i_beat_valid && i_beat_idx == 8'd4) seen = 1;
      end
      chk("reached beat 4", 32'(seen), 32'd1);
      @(posedge clk); #2;
      rst = 1; i_req = 0;
      @(posedge clk);
      @(negedge clk);
      chk("post-rst arvalid", 32'(m_arvalid), 0);
      chk("post-rst i_beat_valid", 32'(i_beat_valid), 0);
      chk("post-rst i_done", 32'(i_done), 0);
      chk("post-rst d_rdata", d_rdata, 0);
      chk("post-rst beats consumed", 32'(q_beat.size()), 0);
      @(posedge clk); #2;
      rst = 0;
      rbase = 32'h77;
      push_dread(32'h8000_0080, 32'h77, 0);
      @(posedge clk); #2;
      d_we = 0; d_addr = 32'h8000_0080; d_req = 1;
      run(100);

      // arready stuck 100 cycles with a pending data write behind the burst
      ar_delay = 1000; rbase = 32'h300;
      push_iburst(32'h0000_6000, 16, 0);
      push_dwrite(32'h0000_0020, 32'h1234_5678, 4'b1111, 0);
      @(posedge clk); #2;
      i_addr = 32'h0000_6000; i_req = 1;
      d_we = 1; d_addr = 32'h0000_0020; d_wdata = 32'h1234_5678; d_wstrb = 4'b1111; d_req = 1;
      @(posedge clk);
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         chk("stall arvalid", 32'(m_arvalid), 1);
         chk("stall araddr", m_araddr, 32'h0000_6000);
         chk("stall awvalid", 32'(m_awvalid), 0);
      end
      ar_delay = 0;
      run(300);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d compared / %0d mismatched",
               n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

endmodule
